// File: rtl/arm_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package arm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        FLUSH,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int LenWidth     = 16;
    localparam int BytesPerWord = 4;

endpackage

// File: rtl/arm_word_assembler.sv
// Collects little-endian bytes into a word; word_full marks the byte that completes it.
module arm_word_assembler
    import arm_loader_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                clear,
    input  logic                accept,
    input  logic [7:0]          data_byte,
    output logic [BusWidth-1:0] word,
    output logic                word_full
);

    logic [BusWidth-1:0] shift_q;
    logic [1:0]          byte_idx_q;

    // Newest byte enters at the top so the first byte ends up in [7:0].
    assign word      = {data_byte, shift_q[BusWidth-1:8]};
    assign word_full = accept && (byte_idx_q == 2'(BytesPerWord - 1));

    always_ff @(posedge i_CLK) begin
        if (i_RESET || clear) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else if (accept) begin
            shift_q    <= word;
            byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/arm_program_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction RAM.
// Optional trailing XOR checksum byte: define ARM_LOADER_CHECKSUM_EN.
module arm_program_loader
    import arm_loader_pkg::*;
#(
    parameter int          BusWidth     = 32,
    parameter int          InstrMemSize = 64,
    parameter logic [31:0] BaseAddr     = 32'h0000_0000
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_Start,
    input  logic                i_Byte_Valid,
    input  logic [7:0]          i_Byte,
    output logic                o_Byte_Ready,
    output logic                o_Write_Enable,
    output logic [BusWidth-1:0] o_Address,
    output logic [BusWidth-1:0] o_Write_Data,
    output logic                o_CPU_Hold,
    output logic                o_Done,
    output logic                o_Error
);

    state_t                state_q, state_d;
    logic [LenWidth-1:0]   count_q;
    logic [LenWidth-1:0]   word_idx_q;
    logic [LenWidth-1:0]   count_full;
    logic                  byte_accept;
    logic                  data_accept;
    logic                  start_load;
    logic                  last_word;
    logic                  word_full;
    logic [BusWidth-1:0]   asm_word;

    assign byte_accept = i_Byte_Valid && o_Byte_Ready;
    assign data_accept = byte_accept && (state_q == DATA);
    assign start_load  = i_Start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign count_full  = {i_Byte, count_q[7:0]};
    assign last_word   = (word_idx_q == count_q - 1'b1);

`ifdef ARM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge i_CLK) begin
        if (i_RESET || start_load) begin
            csum_q <= '0;
        end else if (data_accept) begin
            csum_q <= csum_q ^ i_Byte;
        end
    end

    assign o_Byte_Ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          (state_q == DATA)   || (state_q == CSUM);
    assign o_CPU_Hold   = o_Byte_Ready || (state_q == FLUSH) || (state_q == ERROR);
`else
    assign o_Byte_Ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign o_CPU_Hold   = o_Byte_Ready || (state_q == FLUSH) || (state_q == ERROR);
`endif
    assign o_Done  = (state_q == DONE);
    assign o_Error = (state_q == ERROR);

    arm_word_assembler #(
        .BusWidth (BusWidth)
    ) u_word_assembler (
        .i_CLK     (i_CLK),
        .i_RESET   (i_RESET),
        .clear     (start_load),
        .accept    (data_accept),
        .data_byte (i_Byte),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (i_Start) state_d = LEN_LO;
            LEN_LO: if (byte_accept) state_d = LEN_HI;
            LEN_HI: begin
                if (byte_accept) begin
                    if (count_full == '0) begin
`ifdef ARM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = FLUSH;
`endif
                    end else if (count_full > LenWidth'(InstrMemSize)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full && last_word) begin
`ifdef ARM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = FLUSH;
`endif
                end
            end
            // Gives the final registered write pulse a cycle before the hold drops.
            FLUSH:  state_d = DONE;
`ifdef ARM_LOADER_CHECKSUM_EN
            CSUM:   if (byte_accept) state_d = (i_Byte == csum_q) ? DONE : ERROR;
`endif
            DONE:   if (i_Start) state_d = LEN_LO;
            ERROR:  if (i_Start) state_d = LEN_LO;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q        <= IDLE;
            count_q        <= '0;
            word_idx_q     <= '0;
            o_Write_Enable <= 1'b0;
            o_Address      <= BaseAddr;
            o_Write_Data   <= '0;
        end else begin
            state_q        <= state_d;
            o_Write_Enable <= word_full;
            if (start_load) begin
                count_q    <= '0;
                word_idx_q <= '0;
            end else if (byte_accept && state_q == LEN_LO) begin
                count_q[7:0] <= i_Byte;
            end else if (byte_accept && state_q == LEN_HI) begin
                count_q <= count_full;
            end
            if (word_full) begin
                o_Write_Data <= asm_word;
                o_Address    <= BaseAddr + BusWidth'({word_idx_q, 2'b00});
                word_idx_q   <= word_idx_q + 1'b1;
            end
        end
    end

endmodule
